// File: rtl/keypad_pkg.sv
// Shared key codes and FSM state type for the keypad entry buffer.
package keypad_pkg;

  localparam logic [3:0] KEY_BACKSPACE = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hE;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_e;

endpackage

// File: rtl/key_press_detect.sv
// Rising-edge detector on the scan controller's key_valid level.
module key_press_detect (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_value,
  output logic       o_press,
  output logic [3:0] o_key_code
);

  logic r_key_prev;

  // Reset to 1 so a key held across reset release never counts as a press.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_key_prev <= 1'b1;
    end else begin
      r_key_prev <= i_key_valid;
    end
  end

  assign o_press    = i_key_valid & ~r_key_prev;
  assign o_key_code = i_key_value;

endmodule

// File: rtl/keypad_entry_buffer.sv
// Multi-digit BCD entry register driven by keypad presses: shift-in, backspace,
// clear, enter/commit, with optional inactivity timeout.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                         clk,
  input  logic                         reset_p,
  input  logic [3:0]                   key_value,
  input  logic                         key_valid,
  output logic [4*DIGITS-1:0]          entry_value,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         entry_full,
  output logic [4*DIGITS-1:0]          committed_value,
  output logic                         commit_valid,
  output logic                         reject,
  output logic                         timeout
);

  localparam int unsigned EW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DIGITS);
  localparam logic [31:0]   TMO_LIMIT = TIMEOUT_CYC;

  state_e          r_state, w_state_d;
  logic [EW-1:0]   r_entry, w_entry_d;
  logic [CW-1:0]   r_count, w_count_d;
  logic [EW-1:0]   r_committed, w_committed_d;
  logic            r_commit_valid, w_commit_valid_d;
  logic            r_reject, w_reject_d;
  logic            r_timeout, w_timeout_d;
  logic [31:0]     r_tmo_cnt, w_tmo_cnt_d;
  logic [31:0]     w_tmo_inc;
  logic            w_press;
  logic [3:0]      w_code;
  logic            w_op;

  key_press_detect u_key_press_detect (
    .clk         (clk),
    .reset_p     (reset_p),
    .i_key_valid (key_valid),
    .i_key_value (key_value),
    .o_press     (w_press),
    .o_key_code  (w_code)
  );

  assign w_op      = w_press && (r_state == S_IDLE);
  assign w_tmo_inc = r_tmo_cnt + 32'd1;

  always_comb begin
    w_state_d        = r_state;
    w_entry_d        = r_entry;
    w_count_d        = r_count;
    w_committed_d    = r_committed;
    w_commit_valid_d = 1'b0;
    w_reject_d       = 1'b0;
    w_timeout_d      = 1'b0;
    w_tmo_cnt_d      = 32'd0;

    unique case (r_state)
      S_IDLE: if (w_op) w_state_d = S_HELD;
      S_HELD: if (!key_valid) w_state_d = S_IDLE;
      default: w_state_d = S_HELD;
    endcase

    if (w_op) begin
      if (w_code <= 4'd9) begin
        if (r_count < FULL_CNT) begin
          w_entry_d = (r_entry << 4) | EW'(w_code);
          w_count_d = r_count + CW'(1);
        end else begin
          w_reject_d = 1'b1;
        end
      end else begin
        case (w_code)
          KEY_BACKSPACE: begin
            if (r_count != '0) begin
              w_entry_d = r_entry >> 4;
              w_count_d = r_count - CW'(1);
            end
          end
          KEY_CLEAR: begin
            w_entry_d = '0;
            w_count_d = '0;
          end
          KEY_ENTER: begin
            if (r_count != '0) begin
              w_committed_d    = r_entry;
              w_commit_valid_d = 1'b1;
              w_entry_d        = '0;
              w_count_d        = '0;
            end else begin
              w_reject_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if ((TMO_LIMIT != 32'd0) && (r_state == S_IDLE) && (r_count != '0)) begin
      // A press on the expiry edge takes the branch above, so it wins.
      if (w_tmo_inc >= TMO_LIMIT) begin
        w_entry_d   = '0;
        w_count_d   = '0;
        w_timeout_d = 1'b1;
      end else begin
        w_tmo_cnt_d = w_tmo_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state        <= S_HELD;
      r_entry        <= '0;
      r_count        <= '0;
      r_committed    <= '0;
      r_commit_valid <= 1'b0;
      r_reject       <= 1'b0;
      r_timeout      <= 1'b0;
      r_tmo_cnt      <= 32'd0;
    end else begin
      r_state        <= w_state_d;
      r_entry        <= w_entry_d;
      r_count        <= w_count_d;
      r_committed    <= w_committed_d;
      r_commit_valid <= w_commit_valid_d;
      r_reject       <= w_reject_d;
      r_timeout      <= w_timeout_d;
      r_tmo_cnt      <= w_tmo_cnt_d;
    end
  end

  assign entry_value     = r_entry;
  assign digit_count     = r_count;
  assign entry_full      = (r_count == FULL_CNT);
  assign committed_value = r_committed;
  assign commit_valid    = r_commit_valid;
  assign reject          = r_reject;
  assign timeout         = r_timeout;

endmodule

// File: doc/keypad_entry_buffer.md
Name: keypad_entry_buffer

Overview:
- Multi-digit entry buffer between the keypad scan controller (4-bit key code plus level "key held" valid) and the FND/display or application logic.
- Converts each key press into an edit operation on a BCD entry register of DIGITS nibbles: digit shift-in, backspace, clear, enter/commit.
- Supports inactivity timeout.
- Parametrised successor to the single-key latch: multi-digit, editable, with a committed-value handshake.

Parameters:
- DIGITS, 4, number of BCD digits held in the entry register (legal 1..8).
- TIMEOUT_CYC, 0, clk cycles of no press before a partial entry auto-clears; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset_p  input  1  asynchronous, active-high reset
- key_value  input  4  key code from the scan controller; valid while key_valid=1
- key_valid  input  1  level, high while a key is held
- entry_value  output  4*DIGITS  live entry; least significant digit is the newest, in nibble [3:0]; unused digits are 0
- digit_count  output  $clog2(DIGITS+1)  number of digits entered
- entry_full  output  1  digit_count==DIGITS
- committed_value  output  4*DIGITS  last committed entry
- commit_valid  output  1  one-cycle pulse when committed_value updates
- reject  output  1  one-cycle pulse on an illegal operation
- timeout  output  1  one-cycle pulse when the timeout clears the entry

Behaviour:
- Reset: all outputs 0; FSM in S_HELD; key_prev=1. A key held across reset release is ignored until it has been released once.
- Press event: key_valid==1 && key_prev==0 on a clk edge. key_value is sampled on that same edge. Effects (registers and pulses) are visible after that edge, i.e. 1-cycle latency.
- FSM states:
  - S_IDLE: waiting for a press. A press performs the operation and goes to S_HELD.
  - S_HELD: waiting for release. key_valid==0 goes to S_IDLE. No further operation while held; no auto-repeat.
- Key code map:
  - 0x0-0x9 digit.
  - 0xA backspace.
  - 0xB clear.
  - 0xE enter.
  - 0xC, 0xD, 0xF: ignored (no change, no reject).
- Digit:
  - If count<DIGITS: entry=(entry<<4)|code; count+1.
  - If full: entry unchanged; reject pulse.
- Backspace:
  - If count>0: entry>>=4; count-1.
  - If count==0: no-op, no reject.
- Clear: entry=0, count=0. No pulse.
- Enter:
  - If count>0: committed_value=entry and commit_valid pulse, in the same cycle as the entry clears to 0 and count goes to 0.
  - If count==0: reject pulse; committed_value held.
- Timeout (TIMEOUT_CYC>0):
  - Counter resets on every press.
  - Counter increments each cycle while in S_IDLE with count>0.
  - When it reaches TIMEOUT_CYC: entry=0, count=0, timeout pulse, counter cleared.
  - Counter is held at 0 while count==0 or while in S_HELD.
- Simultaneous events: a press and the timeout expiry on the same edge — the press wins; the timeout is suppressed.
- Pulses (commit_valid, reject, timeout) are mutually exclusive and never last longer than 1 cycle.
- Widths:
  - count width $clog2(DIGITS+1).
  - Timeout counter 32 bits, saturating compare.
  - Shifts truncate to 4*DIGITS bits.
- Reset mid-entry: everything returns to the reset values; committed_value is also cleared.

Decomposition:
- Shared package keypad_pkg:
  - key code constants KEY_BACKSPACE=4'hA, KEY_CLEAR=4'hB, KEY_ENTER=4'hE.
  - FSM state enum {S_IDLE, S_HELD}.
- One natural sub-module: key_press_detect. It registers key_valid (reset value 1), outputs the press strobe, and supplies the sampled key_value.

Test Plan:
- Press 1,2,3,4 (each press then release), DIGITS=4 -> entry_value=16'h1234, digit_count=4, entry_full=1. A 5th press of 5 -> reject pulse, entry stays 16'h1234.
- Entry 16'h0123, press A -> 16'h0012, count 2. Press A three more times -> 0, count 0, no reject.
- Entry 16'h0042, press E -> commit_valid for exactly 1 cycle, committed_value=16'h0042, entry_value=0. Press E again -> reject, committed_value stays 16'h0042.
- Hold key 7 with key_valid high for 50 cycles -> exactly one shift-in (entry 16'h0007). Keys C/D/F -> no change, no pulses.
- TIMEOUT_CYC=100, enter digit 9, idle -> timeout pulse exactly 100 cycles after release, entry cleared. A press on the expiry cycle -> the digit is applied and no timeout pulse occurs.
- Assert reset_p mid-entry with key 3 held through reset release -> all outputs 0, and no digit is entered until release followed by a new press.
